mmio_uart_hub: RTL and testbench

Parametrised MMIO front-end between the core's load/store port and the UART byte engines (UartRx/UartTx). It assembles received bytes into words and queues them in an RX FIFO, and serialises words written by the core through a TX FIFO. Width, depth and RX-full policy are parametrised, with sticky overflow status and an explicit access strobe so that a pop happens only on a real load. It sits beside the memory hub and answers every address with bit 31 set.

---
 rtl/mmio_uart_pkg.sv | 24 ++
 rtl/mmio_uart_hub_sync_fifo.sv | 61 ++++++
 rtl/mmio_uart_hub.sv | 166 ++++++++++++++++
 tb/tb_mmio_uart_hub.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_pkg.sv
// rtl/mmio_uart_pkg.sv - shared register offsets, status bits and TX engine states
// Purpose: constants and types used by the MMIO UART hub and its testbench.
// Ports: none (package).
package mmio_uart_pkg;

  localparam logic [3:0] OFS_STATUS   = 4'h0;
  localparam logic [3:0] OFS_RX_DATA  = 4'h1;
  localparam logic [3:0] OFS_RX_COUNT = 4'h2;
  localparam logic [3:0] OFS_TX_DATA  = 4'h4;
  localparam logic [3:0] OFS_TX_FREE  = 4'h8;

  localparam int STS_RX_OVF    = 0;
  localparam int STS_TX_OVF    = 1;
  localparam int STS_TX_ACTIVE = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } tx_state_t;

endpackage

// File: rtl/mmio_uart_hub_sync_fifo.sv
// rtl/mmio_uart_hub_sync_fifo.sv - single-clock word FIFO with optional overwrite-oldest
// Purpose: word queue used for both the RX and TX paths of the hub.
// Ports: clock/reset_n (async active-low), push/push_data, pop, head (current
//        oldest word), full, empty, count (0..DEPTH), overflow (one-cycle pulse
//        when a push meets a full FIFO with no simultaneous pop).
module sync_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter bit OVERWRITE = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;
  logic             adv_rd;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign head   = mem[rd_ptr];
  assign pop_ok = pop && !empty;

  // A pop in the same cycle frees the slot, so a push on a full FIFO is
  // only an overflow when nothing leaves.
  assign overflow = push && full && !pop_ok;
  assign push_ok  = push && (!full || pop_ok || OVERWRITE);
  // In overwrite mode the head slot is reused, so the read side advances too.
  assign adv_rd   = pop_ok || (overflow && OVERWRITE);

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (adv_rd)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !adv_rd)      count <= count + 1'b1;
      else if (adv_rd && !push_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/mmio_uart_hub.sv
// rtl/mmio_uart_hub.sv - MMIO front-end joining the core load/store port to the UART byte engines
// Purpose: assembles received bytes into words queued in an RX FIFO and
//          serialises core-written words from a TX FIFO, little-endian.
// Ports: clock, reset_n (async active-low); access, write_enable, address,
//        write_data, read_data (MMIO side); rx_valid, rx_data (from UartRx);
//        tx_start, sdata, tx_busy (to/from UartTx).
module mmio_uart_hub
  import mmio_uart_pkg::*;
#(
  parameter int RX_DEPTH       = 256,
  parameter int TX_DEPTH       = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter bit RX_OVERWRITE   = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        access,
  input  logic        write_enable,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_start,
  output logic [7:0]  sdata,
  input  logic        tx_busy
);

  localparam int DW  = 8 * BYTES_PER_WORD;
  localparam int LW  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(BYTES_PER_WORD - 1);

  logic [3:0] ofs;
  logic       wr_acc, rd_acc, sts_wr;
  assign ofs    = address[3:0];
  assign wr_acc = access && write_enable;
  assign rd_acc = access && !write_enable;
  assign sts_wr = wr_acc && (ofs == OFS_STATUS);

  // RX assembly
  logic [LW-1:0]  rx_lane;
  logic [DW-1:0]  rx_asm, rx_word, rx_head;
  logic           rx_push, rx_empty, rx_full, rx_of;
  logic [RCW-1:0] rx_count;

  always_comb begin
    rx_word = rx_asm;
    rx_word[{rx_lane, 3'b000} +: 8] = rx_data;
  end
  assign rx_push = rx_valid && (rx_lane == LAST_LANE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_lane <= '0;
      rx_asm  <= '0;
    end else if (rx_valid) begin
      rx_asm  <= rx_word;
      rx_lane <= (rx_lane == LAST_LANE) ? '0 : rx_lane + 1'b1;
    end
  end

  sync_fifo #(.WIDTH(DW), .DEPTH(RX_DEPTH), .OVERWRITE(RX_OVERWRITE)) rx_fifo (
    .clock(clock), .reset_n(reset_n),
    .push(rx_push), .push_data(rx_word),
    .pop(rd_acc && (ofs == OFS_RX_DATA)),
    .head(rx_head), .full(rx_full), .empty(rx_empty),
    .count(rx_count), .overflow(rx_of)
  );

  // TX FIFO and engine
  logic [DW-1:0]  tx_head, tx_word;
  logic           tx_empty, tx_full, tx_of, tx_deq, tx_active;
  logic [TCW-1:0] tx_count;
  logic [LW-1:0]  tx_lane, tx_lane_nx;
  tx_state_t      state, state_next;

  sync_fifo #(.WIDTH(DW), .DEPTH(TX_DEPTH), .OVERWRITE(1'b0)) tx_fifo (
    .clock(clock), .reset_n(reset_n),
    .push(wr_acc && (ofs == OFS_TX_DATA)), .push_data(write_data[DW-1:0]),
    .pop(tx_deq),
    .head(tx_head), .full(tx_full), .empty(tx_empty),
    .count(tx_count), .overflow(tx_of)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!tx_empty) state_next = LOAD;
      LOAD:      state_next = START;
      START:     state_next = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) state_next = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_next = (tx_lane != LAST_LANE) ? START : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_start  = (state == START);
    tx_deq    = (state == IDLE) && !tx_empty;
    tx_active = (state != IDLE);
  end

  assign tx_lane_nx = tx_lane + 1'b1;

  // sdata is loaded on the edge entering START so it is already valid
  // during the tx_start pulse and stays put until the next lane.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_word <= '0;
      tx_lane <= '0;
      sdata   <= '0;
    end else begin
      if (tx_deq) begin
        tx_word <= tx_head;
        tx_lane <= '0;
      end
      if (state == LOAD) sdata <= tx_word[7:0];
      if (state == WAIT_DONE && !tx_busy && tx_lane != LAST_LANE) begin
        tx_lane <= tx_lane_nx;
        sdata   <= tx_word[{tx_lane_nx, 3'b000} +: 8];
      end
    end
  end

  // Sticky overflow flags; a new overflow in the clearing cycle wins.
  logic rx_ovf, tx_ovf;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_ovf <= 1'b0;
      tx_ovf <= 1'b0;
    end else begin
      rx_ovf <= (rx_ovf && !(sts_wr && write_data[0])) || rx_of;
      tx_ovf <= (tx_ovf && !(sts_wr && write_data[1])) || tx_of;
    end
  end

  logic [31:0] status_word;
  always_comb begin
    status_word                = '0;
    status_word[STS_RX_OVF]    = rx_ovf;
    status_word[STS_TX_OVF]    = tx_ovf;
    status_word[STS_TX_ACTIVE] = tx_active;
  end

  always_comb begin
    read_data = '0;
    case (ofs)
      OFS_STATUS:   read_data = status_word;
      OFS_RX_DATA:  read_data = rx_empty ? '0 : 32'(rx_head);
      OFS_RX_COUNT: read_data = 32'(rx_count);
      OFS_TX_FREE:  read_data = 32'(TCW'(TX_DEPTH) - tx_count);
      default:      read_data = '0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{address[31:4], write_data, rx_full, tx_full};

endmodule

// File: tb/tb_mmio_uart_hub.sv
// tb/tb_mmio_uart_hub.sv - self-checking bench for mmio_uart_hub (drop and overwrite RX policies)
module tb_mmio_uart_hub;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        access, write_enable;
  logic [31:0] address, write_data;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_busy;
  logic [31:0] read_data0, read_data1;
  logic        tx_start0, tx_start1;
  logic [7:0]  sdata0, sdata1;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mmio_uart_hub #(.RX_DEPTH(4), .TX_DEPTH(8), .BYTES_PER_WORD(4), .RX_OVERWRITE(1'b0)) dut0 (
    .clock(clock), .reset_n(reset_n), .access(access), .write_enable(write_enable),
    .address(address), .write_data(write_data), .read_data(read_data0),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_start(tx_start0), .sdata(sdata0),
    .tx_busy(tx_busy)
  );

  mmio_uart_hub #(.RX_DEPTH(4), .TX_DEPTH(8), .BYTES_PER_WORD(4), .RX_OVERWRITE(1'b1)) dut1 (
    .clock(clock), .reset_n(reset_n), .access(access), .write_enable(write_enable),
    .address(address), .write_data(write_data), .read_data(read_data1),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_start(tx_start1), .sdata(sdata1),
    .tx_busy(tx_busy)
  );

  // Reference model: RX queues per policy, sticky flags, expected TX byte stream.
  logic [31:0] mq0[$], mq1[$];
  logic [7:0]  exp_tx[$], rec0[$], rec1[$];
  bit          movf0, movf1;
  bit          hold_busy = 1'b0;
  int          busy_cnt = 0;

  // UartTx model: captures sdata on each tx_start, stays busy for 10 cycles.
  always @(negedge clock) begin
    if (!reset_n) begin
      busy_cnt = 0;
    end else begin
      if (busy_cnt > 0) busy_cnt--;
      if (tx_start0) begin
        rec0.push_back(sdata0);
        busy_cnt = 10;
      end
      if (tx_start1) rec1.push_back(sdata1);
    end
    tx_busy = (busy_cnt > 0) || hold_busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d0, output logic [31:0] d1);
    access = 1'b1; write_enable = 1'b0; address = {28'h8000000, a};
    #1;
    d0 = read_data0; d1 = read_data1;
    tick();
    access = 1'b0; address = 32'h8000_0000;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] e0, input logic [31:0] e1);
    logic [31:0] d0, d1;
    rd(a, d0, d1);
    chk({tag, "_drop"}, d0, e0);
    chk({tag, "_ovwr"}, d1, e1);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    access = 1'b1; write_enable = 1'b1; address = {28'h8000000, a}; write_data = d;
    tick();
    access = 1'b0; write_enable = 1'b0; address = 32'h8000_0000;
  endtask

  task automatic pop_chk(input string tag);
    logic [31:0] e0, e1;
    e0 = (mq0.size() > 0) ? mq0.pop_front() : 32'h0;
    e1 = (mq1.size() > 0) ? mq1.pop_front() : 32'h0;
    rd_chk(tag, 4'h1, e0, e1);
  endtask

  task automatic model_rx_push(input logic [31:0] w);
    if (mq0.size() == 4) movf0 = 1'b1;
    else mq0.push_back(w);
    if (mq1.size() == 4) begin
      movf1 = 1'b1;
      mq1.delete(0);
    end
    mq1.push_back(w);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic rx_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) rx_byte(w[8*i +: 8]);
    model_rx_push(w);
  endtask

  task automatic tx_word(input logic [31:0] w, input bit accepted);
    wr(4'h4, w);
    if (accepted) for (int i = 0; i < 4; i++) exp_tx.push_back(w[8*i +: 8]);
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int c = 0;
    while (rec0.size() < n && c < budget) begin
      tick();
      c++;
    end
    repeat (20) tick();
  endtask

  task automatic stream_chk(input string tag);
    chk({tag, "_len_drop"}, 32'(rec0.size()), 32'(exp_tx.size()));
    chk({tag, "_len_ovwr"}, 32'(rec1.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size(); i++) begin
      if (i < rec0.size()) chk($sformatf("%s_byte%0d_drop", tag, i), 32'(rec0[i]), 32'(exp_tx[i]));
      if (i < rec1.size()) chk($sformatf("%s_byte%0d_ovwr", tag, i), 32'(rec1[i]), 32'(exp_tx[i]));
    end
    exp_tx.delete(); rec0.delete(); rec1.delete();
  endtask

  initial begin
    logic [31:0] w;
    reset_n = 1'b0; access = 1'b0; write_enable = 1'b0; address = 32'h8000_0000;
    write_data = '0; rx_valid = 1'b0; rx_data = '0; tx_busy = 1'b0;
    movf0 = 1'b0; movf1 = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    tick();

    // Reset state
    chk("rst_tx_start", 32'(tx_start0), 32'd0);
    chk("rst_sdata", 32'(sdata0), 32'd0);
    rd_chk("rst_status", 4'h0, 0, 0);
    rd_chk("rst_rx_count", 4'h2, 0, 0);
    rd_chk("rst_tx_free", 4'h8, 8, 8);
    rd_chk("rst_bad_ofs", 4'h3, 0, 0);
    pop_chk("rst_pop_empty");
    rd_chk("rst_rx_count2", 4'h2, 0, 0);

    // RX assembly, partial word invisible
    rx_byte(8'h11); rx_byte(8'h22); rx_byte(8'h33);
    rd_chk("rx_mid_count", 4'h2, 0, 0);
    rx_byte(8'h44);
    model_rx_push(32'h4433_2211);
    rd_chk("rx_count1", 4'h2, 1, 1);
    pop_chk("rx_word");
    rd_chk("rx_count0", 4'h2, 0, 0);

    // RX overflow with random words, both policies
    for (int i = 0; i < 5; i++) rx_word($urandom);
    rd_chk("ovf_count", 4'h2, 4, 4);
    rd_chk("ovf_status", 4'h0, {31'b0, movf0}, {31'b0, movf1});
    for (int i = 0; i < 4; i++) pop_chk($sformatf("ovf_pop%0d", i));
    wr(4'h0, 32'h1);
    movf0 = 1'b0; movf1 = 1'b0;
    rd_chk("w1c_status", 4'h0, 0, 0);
    pop_chk("ovf_pop_empty");

    // Pop while a word completes on a full RX FIFO
    for (int i = 0; i < 4; i++) rx_word($urandom);
    w = $urandom;
    for (int i = 0; i < 3; i++) rx_byte(w[8*i +: 8]);
    begin
      logic [31:0] e0, e1;
      e0 = mq0.pop_front(); e1 = mq1.pop_front();
      rx_valid = 1'b1; rx_data = w[31:24];
      access = 1'b1; write_enable = 1'b0; address = 32'h8000_0001;
      #1;
      chk("simul_pop_drop", read_data0, e0);
      chk("simul_pop_ovwr", read_data1, e1);
      tick();
      rx_valid = 1'b0; access = 1'b0; address = 32'h8000_0000;
      model_rx_push(w);
    end
    rd_chk("simul_status", 4'h0, {31'b0, movf0}, {31'b0, movf1});
    rd_chk("simul_count", 4'h2, 4, 4);
    for (int i = 0; i < 4; i++) pop_chk($sformatf("simul_drain%0d", i));

    // TX serialisation and first-start latency
    tx_word(32'hA1B2_C3D4, 1'b1);
    chk("tx_lat0", 32'(tx_start0), 0);
    rd_chk("tx_free7", 4'h8, 7, 7);
    chk("tx_lat1", 32'(tx_start0), 0);
    tick();
    chk("tx_lat2", 32'(tx_start0), 1);
    chk("tx_first_sdata", 32'(sdata0), 32'hD4);
    wait_bytes(4, 300);
    rd_chk("tx_free8", 4'h8, 8, 8);
    rd_chk("tx_idle_status", 4'h0, 0, 0);
    stream_chk("tx_fixed");

    // Random back-to-back TX words
    for (int i = 0; i < 3; i++) tx_word($urandom, 1'b1);
    wait_bytes(12, 1000);
    stream_chk("tx_rand");

    // TX full boundary with the engine stalled
    hold_busy = 1'b1;
    tx_word($urandom, 1'b1);
    repeat (6) tick();
    for (int i = 0; i < 8; i++) tx_word($urandom, 1'b1);
    rd_chk("txfull_free", 4'h8, 0, 0);
    rd_chk("txfull_status", 4'h0, 32'h4, 32'h4);
    tx_word($urandom, 1'b0);
    rd_chk("txovf_status", 4'h0, 32'h6, 32'h6);
    rd_chk("txovf_free", 4'h8, 0, 0);
    hold_busy = 1'b0;
    wait_bytes(36, 3000);
    stream_chk("txfull");
    wr(4'h0, 32'h2);
    rd_chk("txovf_w1c", 4'h0, 0, 0);

    // Reset during WAIT_DONE with a partial RX word pending
    tx_word($urandom | 32'h1, 1'b0);
    begin
      int c = 0;
      while (rec0.size() < 1 && c < 50) begin tick(); c++; end
    end
    chk("rstmid_started", 32'(rec0.size()), 1);
    repeat (4) tick();
    rx_byte(8'h5A); rx_byte(8'hA5);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid_tx_start", 32'(tx_start0), 0);
    chk("rstmid_sdata_drop", 32'(sdata0), 0);
    chk("rstmid_sdata_ovwr", 32'(sdata1), 0);
    address = 32'h8000_0008; #1;
    chk("rstmid_tx_free", read_data0, 8);
    address = 32'h8000_0000; #1;
    chk("rstmid_status", read_data0, 0);
    @(posedge clock); #1 reset_n = 1'b1;
    mq0.delete(); mq1.delete(); exp_tx.delete(); rec0.delete(); rec1.delete();
    rd_chk("rstmid_rx_count", 4'h2, 0, 0);
    rx_word($urandom);
    rd_chk("rstmid_rx_count1", 4'h2, 1, 1);
    pop_chk("rstmid_rx_word");
    repeat (30) tick();
    chk("rstmid_no_tx", 32'(rec0.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
